// File: rtl/axi_sync_pkg.sv
// Shared definitions for the sync-word framer and its receive-side deframer.
// Holds the FSM encoding and the frame_len==0 substitution value.
package axi_sync_pkg;

  typedef enum logic {
    S_SYNC    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_e;

  // A programmed frame length of zero is treated as this many payload beats.
  localparam int unsigned FRAME_LEN_ZERO_SUB = 1;

endpackage

// File: rtl/axi_sync_word_insert_if.sv
// AXI-stream style beat bus used on both sides of the sync-word framer.
// A beat transfers on a rising clk edge where valid & ready are both 1; a source
// holding valid=1 keeps data/user stable until that edge, and ready may depend
// combinationally on the sink's own downstream state but never on valid.
interface axi_sync_word_insert_if #(
  parameter int DWIDTH = 64,
  parameter int UWIDTH = 1
);

  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;
  logic [UWIDTH-1:0] user;

  modport master (output valid, output data, output user, input ready);
  modport slave  (input valid, input data, input user, output ready);

endinterface

// File: rtl/axi_out_reg.sv
// Single output register stage with AXI-style skid-free hold.
// Loads a new beat (or a bubble) whenever the downstream can take it or the stage is empty.
module axi_out_reg #(
  parameter int PWIDTH = 66
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_ready,
  input  logic              i_valid,
  input  logic [PWIDTH-1:0] i_payload,
  output logic              o_valid,
  output logic [PWIDTH-1:0] o_payload,
  output logic              o_advance
);

  logic              r_valid;
  logic [PWIDTH-1:0] r_payload;
  logic              w_advance;

  assign w_advance = i_ready | ~r_valid;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (w_advance) begin
      r_valid <= i_valid;
      // Bubbles leave the old payload in place; only valid matters then.
      if (i_valid) begin
        r_payload <= i_payload;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;
  assign o_advance = w_advance;

endmodule

// File: rtl/axi_sync_word_insert.sv
// Transmit-side framer: emits sync_word ahead of every frame of frame_len payload
// beats, through one output register stage at full throughput within a frame.
module axi_sync_word_insert
  import axi_sync_pkg::*;
#(
  parameter int DWIDTH    = 64,
  parameter int UWIDTH    = 1,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [DWIDTH-1:0]     sync_word,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  axi_sync_word_insert_if.slave  s_axi,
  axi_sync_word_insert_if.master m_axi,
  output logic                  m_axi_sync,
  output logic                  frame_done,
  output state_e                dbg_state
);

  localparam int PWIDTH = DWIDTH + UWIDTH + 1;

  state_e                 r_state;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic                   r_frame_done;

  logic                   w_advance;
  logic                   w_s_ready;
  logic                   w_ld_valid;
  logic [PWIDTH-1:0]      w_ld_payload;
  logic                   w_out_valid;
  logic [PWIDTH-1:0]      w_out_payload;

  // Load mux into the output stage; payload layout is {sync, user, data}.
  always_comb begin
    w_s_ready    = 1'b0;
    w_ld_valid   = 1'b0;
    w_ld_payload = {1'b0, s_axi.user, s_axi.data};
    case (r_state)
      S_SYNC: begin
        w_ld_valid   = enable;
        w_ld_payload = {1'b1, {UWIDTH{1'b0}}, sync_word};
      end
      S_PAYLOAD: begin
        w_s_ready  = w_advance;
        w_ld_valid = s_axi.valid;
      end
      default: begin
        w_s_ready  = 1'b0;
        w_ld_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state      <= S_SYNC;
      r_remaining  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_SYNC: begin
          if (w_advance && enable) begin
            r_remaining <= (frame_len == '0) ? LEN_WIDTH'(FRAME_LEN_ZERO_SUB) : frame_len;
            r_state     <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_advance && s_axi.valid) begin
            // The last beat returns to S_SYNC; the counter never drops below 1.
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_state      <= S_SYNC;
              r_frame_done <= 1'b1;
            end else begin
              r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  axi_out_reg #(
    .PWIDTH(PWIDTH)
  ) u_out_reg (
    .clk       (clk),
    .aresetn   (aresetn),
    .i_ready   (m_axi.ready),
    .i_valid   (w_ld_valid),
    .i_payload (w_ld_payload),
    .o_valid   (w_out_valid),
    .o_payload (w_out_payload),
    .o_advance (w_advance)
  );

  assign s_axi.ready = w_s_ready;
  assign m_axi.valid = w_out_valid;
  assign {m_axi_sync, m_axi.user, m_axi.data} = w_out_payload;
  assign frame_done  = r_frame_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_axi_sync_word_insert.sv
// Randomized bench for axi_sync_word_insert: a frame-level stream model builds the
// expected output sequence from accepted input beats; per-cycle checks cover timing.
module tb_axi_sync_word_insert;
  import axi_sync_pkg::*;

  localparam int DW = 64;
  localparam int UW = 1;
  localparam int LW = 16;
  localparam int W  = DW + UW + 1;

  // clock / reset
  logic          clk;
  logic          aresetn;
  logic          enable;
  logic [DW-1:0] sync_word;
  logic [LW-1:0] frame_len;
  logic          m_axi_sync;
  logic          frame_done;
  state_e        dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_sync_word_insert_if #(.DWIDTH(DW), .UWIDTH(UW)) s_if ();
  axi_sync_word_insert_if #(.DWIDTH(DW), .UWIDTH(UW)) m_if ();

  axi_sync_word_insert #(
    .DWIDTH(DW), .UWIDTH(UW), .LEN_WIDTH(LW)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .enable     (enable),
    .sync_word  (sync_word),
    .frame_len  (frame_len),
    .s_axi      (s_if),
    .m_axi      (m_if),
    .m_axi_sync (m_axi_sync),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // scoreboard
  int            n_total = 0;
  int            n_bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];

  int            m_count  = 0;     // payload beats accepted in the current frame
  int            m_len    = 1;     // effective length of the current frame
  bit            m_sflag  = 1'b0;  // next frame's sync already expected and seen
  int            m_plen   = 1;     // length latched with that pending sync
  bit            pend_done = 1'b0;
  bit            pend_in_v = 1'b0;
  logic [W-1:0]  pend_in_w;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_w;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int eff_len(input logic [LW-1:0] fl);
    return (fl == '0) ? 1 : int'(fl);
  endfunction

  function automatic logic [W-1:0] sync_beat();
    return {1'b1, {UW{1'b0}}, sync_word};
  endfunction

  // Monitor: inputs are stable at the falling edge, so handshakes seen here
  // are the transfers of the next rising edge.
  always @(negedge clk) begin
    logic [W-1:0] ow;
    logic [W-1:0] iw;
    bit           stall;
    ow = {m_axi_sync, m_if.user, m_if.data};
    if (!aresetn) begin
      m_count    = 0;
      m_sflag    = 1'b0;
      pend_done  = 1'b0;
      pend_in_v  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("frame_done", W'(frame_done), W'(pend_done));
      if (pend_in_v) begin
        chk("lat_valid", W'(m_if.valid), W'(1));
        chk("lat_beat", ow, pend_in_w);
      end
      if (prev_stall) begin
        chk("hold_valid", W'(m_if.valid), W'(1));
        chk("hold_beat", ow, prev_w);
      end
      stall = m_if.valid & ~m_if.ready;
      if (stall) chk("s_ready_stall", W'(s_if.ready), W'(0));
      if (m_if.valid && m_if.ready) obs_q.push_back(ow);
      pend_done = 1'b0;
      pend_in_v = 1'b0;
      if (s_if.valid && s_if.ready) begin
        iw = {1'b0, s_if.user, s_if.data};
        if (m_count == 0) begin
          if (m_sflag) begin
            m_sflag = 1'b0;
            m_len   = m_plen;
          end else begin
            exp_q.push_back(sync_beat());
            m_len = eff_len(frame_len);
          end
        end
        exp_q.push_back(iw);
        m_count++;
        if (m_count == m_len) begin
          m_count   = 0;
          pend_done = 1'b1;
        end
        pend_in_v = 1'b1;
        pend_in_w = iw;
      end
      prev_stall = stall;
      prev_w     = ow;
    end
  end

  // driver tasks
  task automatic drive(input int n, input int gap_mode, input int rdy_mode,
                       input int drop_after, input bit rnd);
    int            idx = 0;
    int            cyc = 0;
    logic          acc;
    logic [DW-1:0] cur_d;
    logic [UW-1:0] cur_u;
    cur_d = rnd ? {$urandom, $urandom} : DW'(idx + 1);
    cur_u = rnd ? UW'($urandom_range(0, 1)) : UW'(idx);
    while (idx < n && cyc < 3000) begin
      case (gap_mode)
        0:       s_if.valid = 1'b1;
        1:       s_if.valid = (cyc % 2 == 0);
        default: s_if.valid = ($urandom_range(0, 3) != 0);
      endcase
      case (rdy_mode)
        0:       m_if.ready = 1'b1;
        1:       m_if.ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_if.ready = ($urandom_range(0, 2) != 0);
      endcase
      s_if.data = cur_d;
      s_if.user = cur_u;
      @(negedge clk);
      acc = s_if.valid & s_if.ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx == drop_after) enable = 1'b0;
        cur_d = rnd ? {$urandom, $urandom} : DW'(idx + 1);
        cur_u = rnd ? UW'($urandom_range(0, 1)) : UW'(idx);
      end
    end
    if (idx < n) chk("drive_timeout", W'(idx), W'(n));
    s_if.valid = 1'b0;
  endtask

  task automatic finish_phase(input bit with_trailing);
    int n;
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    if (with_trailing && enable && m_count == 0 && !m_sflag) begin
      exp_q.push_back(sync_beat());
      m_sflag = 1'b1;
      m_plen  = eff_len(frame_len);
    end
    chk("stream_len", W'(obs_q.size()), W'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("stream_beat", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic reset_dut(input bit check_outs);
    enable     = 1'b0;
    s_if.valid = 1'b0;
    @(posedge clk);
    #1 aresetn = 1'b0;
    @(posedge clk);
    #1;
    if (check_outs) begin
      chk("rst_m_valid", W'(m_if.valid), W'(0));
      chk("rst_m_data", W'(m_if.data), W'(0));
      chk("rst_m_user", W'(m_if.user), W'(0));
      chk("rst_m_sync", W'(m_axi_sync), W'(0));
      chk("rst_frame_done", W'(frame_done), W'(0));
      chk("rst_state", W'(dbg_state), W'(S_SYNC));
      chk("rst_s_ready", W'(s_if.ready), W'(0));
    end
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn    = 1'b0;
    enable     = 1'b0;
    sync_word  = 64'hA5A5_5A5A_DEAD_BEEF;
    frame_len  = LW'(3);
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.user  = '0;
    m_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_dut(1'b1);

    // basic framing, then the same traffic under a stalling sink
    frame_len = LW'(3);
    enable    = 1'b1;
    drive(6, 0, 0, 0, 1'b0);
    finish_phase(1'b1);
    reset_dut(1'b0);
    enable = 1'b1;
    drive(6, 0, 1, 0, 1'b0);
    finish_phase(1'b1);

    // zero length acts as one
    reset_dut(1'b0);
    frame_len = '0;
    enable    = 1'b1;
    drive(5, 0, 0, 0, 1'b1);
    finish_phase(1'b1);

    // enable dropped mid-frame: frame completes, next sync waits for enable
    reset_dut(1'b0);
    frame_len = LW'(4);
    enable    = 1'b1;
    drive(4, 0, 0, 1, 1'b1);
    finish_phase(1'b1);
    enable = 1'b1;
    drive(4, 0, 0, 0, 1'b1);
    finish_phase(1'b1);

    // reset in the middle of a frame
    reset_dut(1'b0);
    frame_len = LW'(4);
    enable    = 1'b1;
    drive(2, 0, 0, 0, 1'b1);
    finish_phase(1'b0);
    reset_dut(1'b1);
    enable = 1'b1;
    drive(4, 0, 0, 0, 1'b1);
    finish_phase(1'b1);

    // source gaps
    reset_dut(1'b0);
    frame_len = LW'(2);
    enable    = 1'b1;
    drive(6, 1, 0, 0, 1'b1);
    finish_phase(1'b1);

    // random traffic; frame_len changes take effect from the next sync load
    reset_dut(1'b0);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      frame_len = LW'($urandom_range(0, 5));
      drive(20, 2, 2, 0, 1'b1);
      finish_phase(1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
